// File: rtl/param_mode_counter_pkg.sv
// Shared mode encoding for the parametrised multi-mode counter.
package param_mode_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP   = 2'b00;
  localparam mode_t MODE_DOWN = 2'b01;
  localparam mode_t MODE_STEP = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/param_mode_counter_if.sv
// Control/count bundle between a stimulus master and the counter.
interface param_mode_counter_if
  import param_mode_counter_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic             en;
  mode_t            MODO;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] c;
  logic             rco;

  modport master (output en, MODO, a, b, lim, input c, rco);
  modport slave  (input en, MODO, a, b, lim, output c, rco);
endinterface

// File: rtl/param_mode_counter_next.sv
// Combinational next-count and carry for the four counter modes.
// PARAM_MODE_COUNTER_SAT_EN selects clamping instead of wrapping.
module param_mode_counter_next
  import param_mode_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] c,
  input  mode_t            modo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] c_next,
  output logic             carry
);

`ifdef PARAM_MODE_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH:0] step_s;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] wrap_v;

  always_comb begin
    step_s = (b < lim) ? {1'b0, b} : {1'b0, lim};
    sum    = {1'b0, c} + step_s;
    wrap_v = sum - {1'b0, lim} - {{WIDTH{1'b0}}, 1'b1};
    c_next = c;
    carry  = 1'b0;

    if (modo == MODE_LOAD) begin
      c_next = (a < lim) ? a : lim;
    end else if (c > lim) begin
      // lim was lowered under a running count
      c_next = SAT ? lim : '0;
      carry  = 1'b1;
    end else begin
      case (modo)
        MODE_UP: begin
          if (c == lim) begin
            c_next = SAT ? lim : '0;
            carry  = 1'b1;
          end else begin
            c_next = c + ONE;
          end
        end
        MODE_DOWN: begin
          if (c == '0) begin
            c_next = SAT ? '0 : lim;
            carry  = 1'b1;
          end else begin
            c_next = c - ONE;
          end
        end
        default: begin
          // lim=0 clamps the step to zero, yet a nonzero step still wraps
          if (b == '0) begin
            c_next = c;
          end else if (lim == '0) begin
            c_next = '0;
            carry  = 1'b1;
          end else if (sum > {1'b0, lim}) begin
            c_next = SAT ? lim : wrap_v[WIDTH-1:0];
            carry  = 1'b1;
          end else begin
            c_next = sum[WIDTH-1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/param_mode_counter.sv
// Multi-mode counter top: count/rco registers, enable gating, async reset.
// Saturating behaviour is built in when PARAM_MODE_COUNTER_SAT_EN is defined.
module param_mode_counter
  import param_mode_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  param_mode_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_C = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] c_q, c_d, c_nxt;
  logic             rco_q, rco_d, carry;

  param_mode_counter_next #(.WIDTH(WIDTH)) u_next (
    .c      (c_q),
    .modo   (bus.MODO),
    .a      (bus.a),
    .b      (bus.b),
    .lim    (bus.lim),
    .c_next (c_nxt),
    .carry  (carry)
  );

  always_comb begin
    c_d   = c_q;
    rco_d = 1'b0;
    if (bus.en) begin
      c_d   = c_nxt;
      rco_d = carry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q   <= RST_C;
      rco_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      rco_q <= rco_d;
    end
  end

  assign bus.c   = c_q;
  assign bus.rco = rco_q;

endmodule

// File: tb/tb_param_mode_counter.sv
// Randomized and directed bench for param_mode_counter against an arithmetic model.
module tb_param_mode_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

`ifdef PARAM_MODE_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_c   = 0;
  int   m_r   = 0;

  param_mode_counter_if #(.WIDTH(W)) bus ();

  param_mode_counter #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference from the mode rules, using plain integers.
  task automatic model(input int c, input bit en, input int m, input int a,
                       input int b, input int lim, output int cn, output int r);
    int s;
    cn = c;
    r  = 0;
    if (!en) return;
    if (m == 3) begin
      cn = (a < lim) ? a : lim;
    end else if (c > lim) begin
      cn = SAT ? lim : 0;
      r  = 1;
    end else if (m == 0) begin
      if (c == lim) begin cn = SAT ? lim : 0; r = 1; end
      else cn = c + 1;
    end else if (m == 1) begin
      if (c == 0) begin cn = SAT ? 0 : lim; r = 1; end
      else cn = c - 1;
    end else begin
      s = (b < lim) ? b : lim;
      if (b == 0) cn = c;
      else if (lim == 0) begin cn = 0; r = 1; end
      else if (c + s > lim) begin cn = SAT ? lim : c + s - (lim + 1); r = 1; end
      else cn = c + s;
    end
  endtask

  task automatic cyc(input bit en_i, input int m, input int a_i, input int b_i, input int lim_i);
    int cn, r;
    bus.en   = en_i;
    bus.MODO = m[1:0];
    bus.a    = a_i[W-1:0];
    bus.b    = b_i[W-1:0];
    bus.lim  = lim_i[W-1:0];
    model(m_c, en_i, m, a_i, b_i, lim_i, cn, r);
    @(posedge clk);
    m_c = cn;
    m_r = r;
    #1;
    check("c", int'(bus.c), m_c);
    check("rco", int'(bus.rco), m_r);
  endtask

  task automatic cyc_exp(input bit en_i, input int m, input int a_i, input int b_i,
                         input int lim_i, input int ec, input int er);
    cyc(en_i, m, a_i, b_i, lim_i);
    check("lit_c", int'(bus.c), ec);
    check("lit_rco", int'(bus.rco), er);
  endtask

  initial begin
    bus.en = 1'b0; bus.MODO = 2'b00; bus.a = '0; bus.b = '0; bus.lim = '0;
    #12;
    check("rst_c", int'(bus.c), 0);
    check("rst_rco", int'(bus.rco), 0);
    @(negedge clk);
    rst = 1'b1;
    m_c = 0;

    // count to 7, then reset between edges
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 15);
    check("pre_rst_c", int'(bus.c), 7);
    rst = 1'b0;
    #1;
    check("async_rst_c", int'(bus.c), 0);
    check("async_rst_rco", int'(bus.rco), 0);
    m_c = 0;
    @(negedge clk);
    rst = 1'b1;
    cyc_exp(1, 0, 0, 0, 15, 1, 0);

`ifdef PARAM_MODE_COUNTER_SAT_EN
    cyc_exp(1, 3, 8, 0, 9, 8, 0);
    cyc_exp(1, 0, 0, 0, 9, 9, 0);
    cyc_exp(1, 0, 0, 0, 9, 9, 1);
    cyc_exp(1, 0, 0, 0, 9, 9, 1);
    cyc_exp(1, 3, 0, 0, 9, 0, 0);
    cyc_exp(1, 1, 0, 0, 9, 0, 1);
    cyc_exp(1, 3, 12, 0, 9, 9, 0);
    cyc_exp(1, 0, 0, 0, 5, 5, 1);
`else
    // up wrap at lim=9 and at full range
    cyc_exp(1, 3, 0, 0, 9, 0, 0);
    for (int i = 1; i <= 9; i++) cyc_exp(1, 0, 0, 0, 9, i, 0);
    cyc_exp(1, 0, 0, 0, 9, 0, 1);
    cyc_exp(1, 0, 0, 0, 9, 1, 0);
    cyc_exp(1, 3, 15, 0, 15, 15, 0);
    cyc_exp(1, 0, 0, 0, 15, 0, 1);
    // down wrap
    cyc_exp(1, 3, 1, 0, 9, 1, 0);
    cyc_exp(1, 1, 0, 0, 9, 0, 0);
    cyc_exp(1, 1, 0, 0, 9, 9, 1);
    cyc_exp(1, 1, 0, 0, 9, 8, 0);
    // step
    cyc_exp(1, 3, 14, 0, 15, 14, 0);
    cyc_exp(1, 2, 0, 3, 15, 1, 1);
    cyc_exp(1, 3, 5, 0, 9, 5, 0);
    cyc_exp(1, 2, 0, 12, 9, 4, 1);
    cyc_exp(1, 2, 0, 0, 9, 4, 0);
    // load clamp, then out-of-range recovery, then enable low
    cyc_exp(1, 3, 12, 0, 9, 9, 0);
    cyc_exp(1, 0, 0, 0, 5, 0, 1);
    cyc_exp(1, 3, 3, 0, 5, 3, 0);
    for (int i = 0; i < 3; i++) cyc_exp(0, 0, 0, 0, 5, 3, 0);
`endif
    // lim=0 corner
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 2, 0, 5, 0);
    cyc(1, 2, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      int lim_r;
      case ($urandom_range(0, 5))
        0:       lim_r = 0;
        1:       lim_r = MAX;
        default: lim_r = $urandom_range(0, MAX);
      endcase
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3),
          $urandom_range(0, MAX), $urandom_range(0, MAX), lim_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_mode_counter.md
Name: param_mode_counter

Overview:
- Parametrised multi-mode counter with ripple-carry-out (rco) and a programmable terminal value.
- Four modes are selected by MODO: count up, count down, step up by operand b, and load operand a.
- Successor to the team's fixed 4-bit mode counter: generalised in width, with a runtime wrap limit, an enable, and clean out-of-range recovery.
- Used as the datapath counter driven by the team's stimulus generators and as a reusable timer.

Parameters:
- WIDTH, 4, bit width of a, b, lim and c.
- RST_VAL, 0, value loaded into c on reset (must be ≤ 2^WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- en  input  1  count enable; when low, c holds and rco=0.
- MODO  input  2  mode select: 00 up, 01 down, 10 step, 11 load.
- a  input  WIDTH  load value (mode 11).
- b  input  WIDTH  step value (mode 10).
- lim  input  WIDTH  terminal value; legal count range is 0..lim.
- c  output  WIDTH  registered count.
- rco  output  1  registered carry/borrow pulse, high in the cycle c shows the wrapped value.

Behaviour:
- Reset: while rst=0, c=RST_VAL and rco=0, asynchronously. Release is synchronous to the next clk edge; the first update happens on the first edge with rst=1.
- Single-cycle latency: inputs sampled at posedge clk; c and rco update together on that edge. No combinational input-to-output path.
- en=0: c holds, rco=0, regardless of MODO.
- Out-of-range recovery, any counting mode (00/01/10) with en=1: if c > lim (lim lowered at runtime), then c_next=0 and rco=1. This check takes precedence over the mode rules below.
- MODO 00 (up):
  - c == lim: c_next=0, rco=1.
  - Otherwise: c_next=c+1, rco=0.
- MODO 01 (down):
  - c == 0: c_next=lim, rco=1.
  - Otherwise: c_next=c-1, rco=0.
- MODO 10 (step):
  - Effective step s = min(b, lim).
  - sum = c + s, computed in WIDTH+1 bits.
  - sum > lim: c_next = sum-(lim+1), rco=1.
  - Otherwise: c_next=sum, rco=0.
  - b=0: c holds, rco=0.
- MODO 11 (load): c_next = min(a, lim), rco=0.
- lim=0: modes 00/01/10 keep c=0 with rco=1 every enabled cycle, except step with b=0 (rco=0).
- Full range: lim=2^WIDTH-1 gives plain modulo-2^WIDTH behaviour. No arithmetic may overflow the WIDTH+1 intermediate.
- Mode changes take effect on the same edge; no pipeline, no hidden state beyond c and rco.

Optional Feature:
- Macro: PARAM_MODE_COUNTER_SAT_EN.
- Defined: saturating mode.
  - Up and step clamp c at lim instead of wrapping; down clamps c at 0.
  - rco=1 on every enabled cycle in which the clamp is applied, including repeated cycles while pinned.
  - Out-of-range recovery sets c_next=lim (not 0) with rco=1.
  - Load behaviour is unchanged.
- Undefined: wrap behaviour as specified above.

Decomposition:
- Package param_mode_counter_pkg holds:
  - mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_STEP=2'b10, MODE_LOAD=2'b11;
  - a typedef for the 2-bit mode field.
- One natural sub-module: param_mode_counter_next. It is purely combinational and maps (c, MODO, a, b, lim) to (c_next, carry).
- The top module holds only the c/rco registers, en gating and the reset.

Test Plan:
- Reset: rst=0 mid-count (c=7, WIDTH=4) -> c=0 and rco=0 immediately, before any clk edge. After release, up-count resumes from 0 on the first edge.
- Up wrap: WIDTH=4, lim=9, MODO=00, en=1 from c=0 -> c goes 0..9, then 0 with rco=1 for exactly one cycle. With lim=15 the wrap is 15->0, rco=1.
- Down wrap: lim=9, c=1, MODO=01 -> c=0 (rco=0), then 9 (rco=1), then 8 (rco=0).
- Step:
  - lim=15, c=14, b=3 -> c=1, rco=1.
  - lim=9, c=5, b=12 (clamped to 9) -> c=4, rco=1.
  - b=0 -> c holds, rco=0.
- Load and range:
  - MODO=11, a=12, lim=9 -> c=9.
  - Then lim lowered to 5 with MODO=00 -> c=0, rco=1.
  - en=0 for 3 cycles -> c frozen, rco=0.
- SAT_EN build: lim=9, c=8, MODO=00 -> 9 (rco=0), then 9 (rco=1), 9 (rco=1). MODO=01 from c=0 -> stays 0, rco=1.
